// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: turns a stream of already-sampled line bits into
// data words, checking parity and stop bits for every frame.
// Optional macro FRAME_ERR_CNT_EN adds a saturating count of bad frames
// (err_clr / err_count ports).
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop_two,
`ifdef FRAME_ERR_CNT_EN
    input  logic                  err_clr,
    output logic [CNT_WIDTH-1:0]  err_count,
`endif
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_error,
    output logic                  stop_error,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [3:0]              bit_cnt, bit_cnt_next;
    logic                    par_flag, par_flag_next;
    logic                    stop_flag, stop_flag_next;
    logic                    cfg_par_en, cfg_par_en_next;
    logic                    cfg_par_type, cfg_par_type_next;
    logic                    cfg_stop_two, cfg_stop_two_next;
    logic                    frame_end;

    // Out-of-range widths elaborate this empty marker block so they are easy to spot.
    if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || CNT_WIDTH < 1) begin : g_illegal_params
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and frame bookkeeping; nothing moves unless a sampled bit arrives.
    always_comb begin
        state_next        = state;
        shift_next        = shift_reg;
        bit_cnt_next      = bit_cnt;
        par_flag_next     = par_flag;
        stop_flag_next    = stop_flag;
        cfg_par_en_next   = cfg_par_en;
        cfg_par_type_next = cfg_par_type;
        cfg_stop_two_next = cfg_stop_two;
        frame_end         = 1'b0;
        if (bit_valid) begin
            case (state)
                IDLE: begin
                    if (!sampled_bit) begin
                        state_next        = DATA;
                        bit_cnt_next      = '0;
                        par_flag_next     = 1'b0;
                        stop_flag_next    = 1'b0;
                        cfg_par_en_next   = par_en;
                        cfg_par_type_next = par_type;
                        cfg_stop_two_next = stop_two;
                    end
                end
                DATA: begin
                    shift_next = {sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                    if (bit_cnt == 4'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = cfg_par_en ? PARITY : STOP1;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    if (sampled_bit != ((^shift_reg) ^ cfg_par_type)) begin
                        par_flag_next = 1'b1;
                    end
                    state_next = STOP1;
                end
                STOP1: begin
                    if (!sampled_bit) begin
                        stop_flag_next = 1'b1;
                    end
                    if (cfg_stop_two) begin
                        state_next = STOP2;
                    end else begin
                        state_next = IDLE;
                        frame_end  = 1'b1;
                    end
                end
                STOP2: begin
                    if (!sampled_bit) begin
                        stop_flag_next = 1'b1;
                    end
                    state_next = IDLE;
                    frame_end  = 1'b1;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Datapath registers and the one-cycle result pulses issued after each frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            par_flag     <= 1'b0;
            stop_flag    <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_par_type <= 1'b0;
            cfg_stop_two <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            par_error    <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            shift_reg    <= shift_next;
            bit_cnt      <= bit_cnt_next;
            par_flag     <= par_flag_next;
            stop_flag    <= stop_flag_next;
            cfg_par_en   <= cfg_par_en_next;
            cfg_par_type <= cfg_par_type_next;
            cfg_stop_two <= cfg_stop_two_next;
            data_valid   <= frame_end && !par_flag_next && !stop_flag_next;
            par_error    <= frame_end && par_flag_next;
            stop_error   <= frame_end && stop_flag_next;
            if (frame_end) begin
                data_out <= shift_reg;
            end
        end
    end

`ifdef FRAME_ERR_CNT_EN
    // Saturating bad-frame counter; a clear wins over a simultaneous increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (frame_end && (par_flag_next || stop_flag_next) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench for uart_rx_frame_check: a table of directed frames
// followed by hand-written reset-abort and error-counter sequences.
module tb_uart_rx_frame_check;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_type;
        logic       stop_two;
        logic       par_bit;
        logic       stop1;
        logic       stop2;
        int         gap;
        logic       flip;
        logic       exp_valid;
        logic       exp_par;
        logic       exp_stop;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       bit_valid;
    logic       sampled_bit;
    logic       par_en;
    logic       par_type;
    logic       stop_two;
    logic [7:0] data_out;
    logic       data_valid;
    logic       par_error;
    logic       stop_error;
    logic       busy;
`ifdef FRAME_ERR_CNT_EN
    logic       err_clr;
    logic [7:0] err_count;
`endif

    int         num_checks;
    int         num_fails;
    logic [7:0] last_data;
    frame_t     vecs [10];

    uart_rx_frame_check #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .sampled_bit (sampled_bit),
        .par_en      (par_en),
        .par_type    (par_type),
        .stop_two    (stop_two),
`ifdef FRAME_ERR_CNT_EN
        .err_clr     (err_clr),
        .err_count   (err_count),
`endif
        .data_out    (data_out),
        .data_valid  (data_valid),
        .par_error   (par_error),
        .stop_error  (stop_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive on the falling edge, look at outputs just after the rising edge.
    task automatic applyStimulus(input logic bv, input logic sb);
        @(negedge clk);
        bit_valid   = bv;
        sampled_bit = sb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one complete frame, checking mid-frame quiet/busy and the final result.
    task automatic sendFrame(input frame_t f);
        logic [11:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0;
        n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = f.data[i];
            n++;
        end
        if (f.par_en) begin
            bits[n] = f.par_bit;
            n++;
        end
        bits[n] = f.stop1;
        n++;
        if (f.stop_two) begin
            bits[n] = f.stop2;
            n++;
        end
        par_en   = f.par_en;
        par_type = f.par_type;
        stop_two = f.stop_two;
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b1, bits[k]);
            if (k == 0 && f.flip) begin
                par_en   = ~f.par_en;
                par_type = ~f.par_type;
                stop_two = ~f.stop_two;
            end
            if (k < n - 1) begin
                checkOutput("busy_mid", 32'(busy), 32'd1);
                checkOutput("pulse_mid", 32'({data_valid, par_error, stop_error}), 32'd0);
                checkOutput("hold_data", 32'(data_out), 32'(last_data));
                for (int g = 0; g < f.gap; g++) begin
                    applyStimulus(1'b0, 1'b0);
                    checkOutput("busy_gap", 32'(busy), 32'd1);
                end
            end
        end
        checkOutput("busy_end", 32'(busy), 32'd0);
        checkOutput("data_valid", 32'(data_valid), 32'(f.exp_valid));
        checkOutput("par_error", 32'(par_error), 32'(f.exp_par));
        checkOutput("stop_error", 32'(stop_error), 32'(f.exp_stop));
        checkOutput("data_out", 32'(data_out), 32'(f.data));
        last_data = f.data;
    endtask

    initial begin
        num_checks  = 0;
        num_fails   = 0;
        last_data   = 8'h00;
        rst         = 1'b1;
        bit_valid   = 1'b0;
        sampled_bit = 1'b1;
        par_en      = 1'b0;
        par_type    = 1'b0;
        stop_two    = 1'b0;
`ifdef FRAME_ERR_CNT_EN
        err_clr     = 1'b0;
`endif

        //          data   pe  pt  st2 par s1  s2  gap flip val per ser
        vecs[0] = '{8'hA5, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0};
        vecs[1] = '{8'hA5, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
        vecs[2] = '{8'h3C, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1};
        vecs[3] = '{8'h3C, 1, 1, 0, 1, 1, 1, 0, 0, 1, 0, 0};
        vecs[4] = '{8'h00, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        vecs[5] = '{8'hFF, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1};
        vecs[6] = '{8'h81, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1};
        vecs[7] = '{8'h5A, 0, 0, 1, 0, 1, 1, 2, 0, 1, 0, 0};
        vecs[8] = '{8'h96, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0};
        vecs[9] = '{8'hC3, 1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 0};

        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_pulses", 32'({data_valid, par_error, stop_error}), 32'd0);
        checkOutput("reset_data", 32'(data_out), 32'd0);
`ifdef FRAME_ERR_CNT_EN
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
`endif
        rst = 1'b0;

        // Back-to-back frames: each start bit lands in the cycle after the previous frame end.
        for (int v = 0; v < 10; v++) begin
            sendFrame(vecs[v]);
        end
        applyStimulus(1'b0, 1'b1);
        checkOutput("pulse_after_last", 32'({data_valid, par_error, stop_error}), 32'd0);
        checkOutput("hold_after_last", 32'(data_out), 32'hC3);

        // Idle line, then a frame aborted by reset during its fourth data bit.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput("idle_quiet", 32'({busy, data_valid, par_error, stop_error}), 32'd0);
        end
        par_en   = 1'b0;
        stop_two = 1'b0;
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        rst = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_pulses", 32'({data_valid, par_error, stop_error}), 32'd0);
        checkOutput("abort_data", 32'(data_out), 32'd0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abort_quiet", 32'({busy, data_valid, par_error, stop_error}), 32'd0);
        last_data = 8'h00;
        sendFrame('{8'h5A, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0});

`ifdef FRAME_ERR_CNT_EN
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
        last_data = 8'h00;
        checkOutput("cnt_after_reset", 32'(err_count), 32'd0);
        for (int i = 0; i < 260; i++) begin
            sendFrame('{8'h00, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1});
            if (i == 2) begin
                checkOutput("cnt_three", 32'(err_count), 32'd3);
            end
        end
        checkOutput("cnt_saturated", 32'(err_count), 32'd255);
        // Clear asserted in the very cycle an error frame ends.
        for (int k = 0; k < 10; k++) begin
            err_clr = (k == 9);
            applyStimulus(1'b1, 1'b0);
        end
        err_clr = 1'b0;
        checkOutput("clr_stop_error", 32'(stop_error), 32'd1);
        checkOutput("cnt_cleared", 32'(err_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_check.md
UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 8 and set the data bits per frame; legal range 5..9.
REQ-002 Parameter CNT_WIDTH SHALL default to 8 and set the error counter width (FRAME_ERR_CNT_EN only).
REQ-003 Ports SHALL be:
  clk  input  1  clock, single domain
  rst  input  1  reset, synchronous, active-high
  bit_valid  input  1  strobe, one sampled bit per high cycle
  sampled_bit  input  1  sampled line value
  par_en  input  1  parity bit present
  par_type  input  1  0 even, 1 odd
  stop_two  input  1  0 one stop bit, 1 two stop bits
  data_out  output  DATA_WIDTH  last received data, LSB first on line
  data_valid  output  1  one-cycle pulse, error-free frame
  par_error  output  1  one-cycle pulse, parity mismatch
  stop_error  output  1  one-cycle pulse, any stop bit sampled 0
  busy  output  1  high while state is not IDLE
  err_clr  input  1  clear error counter (FRAME_ERR_CNT_EN only)
  err_count  output  CNT_WIDTH  saturating error-frame count (FRAME_ERR_CNT_EN only)
REQ-004 Clock and reset SHALL be clk and rst; one clock, reset synchronous and active-high.

Function
REQ-005 FSM states SHALL be IDLE, DATA, PARITY, STOP1, STOP2; state advances only on cycles with bit_valid=1.
REQ-006 IDLE: bit_valid with sampled_bit=0 SHALL be taken as start bit -> DATA; sampled_bit=1 SHALL keep IDLE.
REQ-007 On the start-bit cycle par_en, par_type and stop_two SHALL be latched; changes mid-frame SHALL be ignored.
REQ-008 DATA: each bit SHALL shift into a DATA_WIDTH register LSB first; after DATA_WIDTH bits -> PARITY if latched par_en, else STOP1.
REQ-009 PARITY: expected bit = XOR of data bits, inverted for odd; mismatch SHALL set an internal parity flag; -> STOP1.
REQ-010 STOP1: sampled_bit=0 SHALL set an internal stop flag; -> STOP2 if latched stop_two, else frame end.
REQ-011 STOP2: sampled_bit=0 SHALL set the stop flag; -> frame end; a STOP1 error SHALL NOT abort the frame.
REQ-012 Frame end: state SHALL return to IDLE and, in the next cycle, data_out SHALL load the shift register and exactly one pulse of data_valid (no flags) or par_error/stop_error (per flag, both possible) SHALL occur.
REQ-013 data_valid SHALL never coincide with par_error or stop_error; data_out SHALL hold between frames.
REQ-014 A start bit SHALL be accepted in the cycle immediately following frame end (back-to-back frames).
REQ-015 bit_valid=0 SHALL hold all state, counters and flags unchanged.
REQ-016 Internal flags SHALL clear on every start-bit acceptance.

Reset
REQ-017 rst=1 at a clock edge SHALL force IDLE, clear shift register, bit counter, flags, data_out=0, data_valid=0, par_error=0, stop_error=0, busy=0, err_count=0.
REQ-018 rst SHALL take priority over bit_valid; a frame in progress SHALL be discarded without any pulse.

Configuration
REQ-019 Macro FRAME_ERR_CNT_EN defined: err_clr/err_count SHALL exist; err_count increments by 1 per frame with par_error or stop_error, saturates at all-ones, err_clr clears it with priority over increment.
REQ-020 Macro FRAME_ERR_CNT_EN undefined: err_clr/err_count and counter logic SHALL be absent; all other behaviour identical.

Verification
REQ-021 DATA_WIDTH=8, par_en=0, stop_two=0, frame 0,0xA5 LSB-first,1 -> data_out=0xA5, data_valid one cycle, no error pulses.
REQ-022 par_en=1, par_type=0, data 0xA5, parity bit 1 -> par_error one cycle, data_valid=0, data_out=0xA5.
REQ-023 stop_two=1, data 0x3C, stop bits 1,0 -> stop_error one cycle only after second stop bit; busy high until then.
REQ-024 Ten idle 1 bits, then rst during 4th data bit, then valid frame 0x5A -> no pulses before frame, data_valid with 0x5A after.
REQ-025 FRAME_ERR_CNT_EN, CNT_WIDTH=8: 260 stop-error frames -> err_count=255; err_clr with concurrent error frame end -> err_count=0.
